// File: rtl/bwdaux_output_allocator.sv
// ============================================================================
//  Module   : bwdaux_output_allocator
//  Purpose  : Round-robin packet allocator for one backward-aux switch output;
//             the winner holds the output until its tail flit is accepted.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bwdaux_output_allocator #(
  parameter int SWITCH_INPUTS = 4,
  parameter int PTR_W         = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [SWITCH_INPUTS-1:0] req_in,
  input  logic [SWITCH_INPUTS-1:0] flit_valid_in,
  input  logic [SWITCH_INPUTS-1:0] tail_in,
  input  logic                     out_ready,
  output logic [SWITCH_INPUTS-1:0] alloc_out,
  output logic                     busy_out,
  output logic [PTR_W-1:0]         rr_ptr_out
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [SWITCH_INPUTS-1:0] alloc_q, alloc_d;
  logic [PTR_W-1:0]         owner_q, owner_d;
  logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;

  logic                     win_found;
  logic [PTR_W-1:0]         win_idx;
  logic [SWITCH_INPUTS-1:0] win_oh;
  logic                     hi_found, lo_found;
  logic [PTR_W-1:0]         hi_idx, lo_idx;
  logic [SWITCH_INPUTS-1:0] hi_oh, lo_oh;
  logic                     release_w;
  logic [PTR_W-1:0]         ptr_after_owner;

  // Two-pass scan: first requester at or above the pointer, else first overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    hi_oh    = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    lo_oh    = '0;
    for (int i = 0; i < SWITCH_INPUTS; i++) begin
      if (req_in[i] && (i >= int'(rr_ptr_q)) && !hi_found) begin
        hi_found  = 1'b1;
        hi_idx    = PTR_W'(i);
        hi_oh[i]  = 1'b1;
      end
      if (req_in[i] && !lo_found) begin
        lo_found  = 1'b1;
        lo_idx    = PTR_W'(i);
        lo_oh[i]  = 1'b1;
      end
    end
    win_found = hi_found | lo_found;
    win_idx   = hi_found ? hi_idx : lo_idx;
    win_oh    = hi_found ? hi_oh  : lo_oh;
  end

  // alloc_q is one-hot in LOCKED, so masking selects the owner's flit bits.
  assign release_w = out_ready & (|(alloc_q & flit_valid_in & tail_in));

  assign ptr_after_owner = (owner_q == PTR_W'(SWITCH_INPUTS - 1)) ? '0
                                                                  : owner_q + PTR_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      alloc_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      alloc_q  <= alloc_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (win_found) state_d = ST_LOCKED;
      ST_LOCKED: if (release_w) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    alloc_d  = alloc_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        alloc_d = '0;
        if (win_found) begin
          alloc_d = win_oh;
          owner_d = win_idx;
        end
      end
      ST_LOCKED: begin
        if (release_w) begin
          alloc_d  = '0;
          rr_ptr_d = ptr_after_owner;
        end
      end
      default: alloc_d = '0;
    endcase
  end

  assign alloc_out  = alloc_q;
  assign busy_out   = |alloc_q;
  assign rr_ptr_out = rr_ptr_q;

endmodule

`default_nettype wire

// File: tb/tb_bwdaux_output_allocator.sv
// ============================================================================
//  Module   : tb_bwdaux_output_allocator
//  Purpose  : Directed self-checking bench for bwdaux_output_allocator.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bwdaux_output_allocator;

  localparam int N  = 4;
  localparam int PW = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  req_in;
  logic [N-1:0]  flit_valid_in;
  logic [N-1:0]  tail_in;
  logic          out_ready;
  logic [N-1:0]  alloc_out;
  logic          busy_out;
  logic [PW-1:0] rr_ptr_out;

  int n_checks = 0;
  int n_fails  = 0;

  bwdaux_output_allocator #(.SWITCH_INPUTS(N), .PTR_W(PW)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_in       (req_in),
    .flit_valid_in(flit_valid_in),
    .tail_in      (tail_in),
    .out_ready    (out_ready),
    .alloc_out    (alloc_out),
    .busy_out     (busy_out),
    .rr_ptr_out   (rr_ptr_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [N-1:0] a, input logic [PW-1:0] p);
    check({tag, ".alloc"}, 32'(alloc_out), 32'(a));
    check({tag, ".busy"},  32'(busy_out),  32'(|a));
    check({tag, ".ptr"},   32'(rr_ptr_out), 32'(p));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] v,
                       input logic [N-1:0] t, input logic rdy);
    req_in        = r;
    flit_valid_in = v;
    tail_in       = t;
    out_ready     = rdy;
  endtask

  logic [N-1:0] rr_alloc [10] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                  4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
  logic [PW-1:0] rr_ptr [10]  = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2,
                                  2'd3, 2'd3, 2'd0, 2'd0, 2'd1};

  initial begin
    reset = 1'b1;
    drive(4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick();
    tick();
    expect_out("reset", 4'b0000, 2'd0);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      expect_out("idle", 4'b0000, 2'd0);
    end

    // single requester, 3-flit packet on input 2
    drive(4'b0100, 4'b0000, 4'b0000, 1'b1);
    tick();
    expect_out("pkt3.grant", 4'b0100, 2'd0);
    drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
    tick();
    expect_out("pkt3.c2", 4'b0100, 2'd0);
    drive(4'b0000, 4'b0100, 4'b0000, 1'b1);
    tick();
    expect_out("pkt3.c3", 4'b0100, 2'd0);
    tick();
    expect_out("pkt3.c4", 4'b0100, 2'd0);
    drive(4'b0000, 4'b0100, 4'b0100, 1'b1);
    tick();
    expect_out("pkt3.release", 4'b0000, 2'd3);

    // round-robin with single-flit packets from a fresh pointer
    drive(4'b0000, 4'b0000, 4'b0000, 1'b0);
    reset = 1'b1;
    tick();
    expect_out("rr.reset", 4'b0000, 2'd0);
    reset = 1'b0;
    drive(4'b1111, 4'b1111, 4'b1111, 1'b1);
    for (int c = 0; c < 9; c++) begin
      tick();
      expect_out($sformatf("rr.c%0d", c), rr_alloc[c], rr_ptr[c]);
    end
    drive(4'b0000, 4'b1111, 4'b1111, 1'b1);
    tick();
    expect_out("rr.c9", rr_alloc[9], rr_ptr[9]);
    drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
    tick();
    expect_out("rr.quiet", 4'b0000, 2'd1);

    // stall and lock: owner 1 with tail held off, input 3 waiting
    drive(4'b1010, 4'b0000, 4'b0000, 1'b0);
    tick();
    expect_out("stall.grant", 4'b0010, 2'd1);
    drive(4'b1000, 4'b0010, 4'b0010, 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      expect_out($sformatf("stall.hold%0d", c), 4'b0010, 2'd1);
    end
    out_ready = 1'b1;
    tick();
    expect_out("stall.release", 4'b0000, 2'd2);
    drive(4'b1000, 4'b0000, 4'b0000, 1'b1);
    tick();
    expect_out("stall.next", 4'b1000, 2'd2);
    drive(4'b0000, 4'b1000, 4'b1000, 1'b1);
    tick();
    expect_out("stall.done", 4'b0000, 2'd0);

    // non-owner tails must not release owner 2
    drive(4'b0100, 4'b0000, 4'b0000, 1'b1);
    tick();
    expect_out("noise.grant", 4'b0100, 2'd0);
    drive(4'b0000, 4'b1011, 4'b1011, 1'b1);
    tick();
    expect_out("noise.n1", 4'b0100, 2'd0);
    tick();
    expect_out("noise.n2", 4'b0100, 2'd0);
    drive(4'b0000, 4'b0100, 4'b0000, 1'b1);
    tick();
    expect_out("noise.body", 4'b0100, 2'd0);
    drive(4'b0000, 4'b0100, 4'b0100, 1'b1);
    tick();
    expect_out("noise.release", 4'b0000, 2'd3);

    // reset while owner 0 is mid-packet
    drive(4'b0001, 4'b0000, 4'b0000, 1'b1);
    tick();
    expect_out("midrst.grant", 4'b0001, 2'd3);
    reset = 1'b1;
    tick();
    expect_out("midrst.reset", 4'b0000, 2'd0);
    reset = 1'b0;
    tick();
    expect_out("midrst.regrant", 4'b0001, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bwdaux_output_allocator.md
Name: bwdaux_output_allocator

Overview:
- Per-output packet allocator for the NoC switch, one instance per backward-aux output port (BWDAUX1..3).
- Arbitrates round-robin among switch inputs whose head flit is a header routed to this output.
- Locks the winner onto the output until its tail flit has transferred.
- Produces the one-hot allocation vector consumed directly by the downstream OR-reduction stage (alloc_BWDAUXn_out -> BWDAUXn_out_c) and by the crossbar select.

Parameters:
SWITCH_INPUTS, 4, number of switch inputs competing for this output; width of all per-input vectors.
PTR_W, 2, width of the round-robin pointer; must satisfy 2**PTR_W >= SWITCH_INPUTS.

Ports:
clock  input  1  switch clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
req_in  input  SWITCH_INPUTS  bit i: input i head flit is a valid header routed to this output.
flit_valid_in  input  SWITCH_INPUTS  bit i: input i presents a valid flit this cycle.
tail_in  input  SWITCH_INPUTS  bit i: flit presented by input i is a tail; header+tail both set means a single-flit packet.
out_ready  input  1  downstream accepts a flit this cycle (credit/stall from output buffer).
alloc_out  output  SWITCH_INPUTS  one-hot (or zero) allocation vector; bit i: output owned by input i.
busy_out  output  1  output currently allocated; equals OR of alloc_out.
rr_ptr_out  output  PTR_W  current highest-priority input index, for debug/verification.

Behaviour:
- Reset (synchronous, on clock edge with reset=1):
  - alloc_out=0, busy_out=0, rr_ptr_out=0, state=IDLE.
  - Overrides everything else, including mid-packet: the allocation is dropped and no tail is waited for.
- All outputs are registered; no combinational path from any input to any output.
- States:
  - IDLE: alloc_out=0.
    - If req_in!=0: select the first set bit of req_in scanning rr_ptr, rr_ptr+1, ... modulo SWITCH_INPUTS.
    - Next cycle: alloc_out=onehot(winner), state=LOCKED.
    - If req_in==0: stay IDLE, pointer unchanged.
  - LOCKED (owner g):
    - alloc_out holds onehot(g); req_in changes are ignored, including withdrawal by g and new requests.
    - Transfer occurs on a cycle with flit_valid_in[g] & out_ready.
    - Release occurs on a transfer with tail_in[g]=1. Next cycle: alloc_out=0, state=IDLE, rr_ptr=(g+1) mod SWITCH_INPUTS.
    - A transfer without tail, or a cycle with flit_valid_in[g]=0 or out_ready=0: no change.
    - flit_valid_in/tail_in bits of non-owners are ignored.
- Latency:
  - Request to alloc_out asserted: 1 cycle.
  - Tail transfer to alloc_out deasserted: 1 cycle.
  - There is no same-cycle re-grant. The IDLE cycle after a release is an arbitration cycle, so back-to-back packets on one output have one bubble cycle.
- Single-flit packet:
  - Granted like any packet.
  - Released on its first accepted transfer, since tail_in[g]=1 on that flit.
- Tail stalled by out_ready=0: alloc_out is held until the cycle the tail is actually accepted.
- Pointer:
  - Advances only on release, never on grant.
  - Wrap-around: owner SWITCH_INPUTS-1 sets the pointer to 0.
- Invariant: popcount(alloc_out)<=1 in every cycle; busy_out==|alloc_out.
- Non-power-of-two SWITCH_INPUTS: pointer arithmetic is modulo SWITCH_INPUTS; values >= SWITCH_INPUTS are never produced.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, req_in=0 -> alloc_out=0000, busy_out=0, rr_ptr_out=0 for 5 cycles.
- Single requester, 3-flit packet:
  - req_in=0100 at cycle 0 -> alloc_out=0100 at cycle 1.
  - Transfers on cycles 2, 3, 4, with tail on cycle 4 -> alloc_out=0000 at cycle 5, rr_ptr_out=3.
- Round-robin fairness: req_in=1111 held, every packet single-flit, out_ready=1 -> grant sequence 0001, 0010, 0100, 1000, 0001 with one idle cycle between grants; pointer wraps 3 -> 0.
- Stall and lock:
  - Owner input 1; out_ready=0 while tail_in[1]=1 for 4 cycles; req_in[3] asserted throughout -> alloc_out stays 0010.
  - out_ready=1 -> alloc_out=0000 next cycle, then 1000 the cycle after.
- Non-owner noise: owner 2; flit_valid_in=1011 with tail_in=1011 and out_ready=1 -> no release, alloc_out remains 0100.
- Reset mid-packet: owner 0 after header, no tail yet; reset=1 for one cycle -> alloc_out=0000, rr_ptr_out=0 next cycle; with req_in=0001 held, re-grant 0001 one cycle after reset falls.
